// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, operand classes,
// canonical-NaN construction and exception-flag bit positions.
package fp_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  // Operand class; CLS_NORM on a result means "no special override".
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  localparam int FLG_NAN_IN    = 0;
  localparam int FLG_INEXACT   = 1;
  localparam int FLG_UNDERFLOW = 2;
  localparam int FLG_OVERFLOW  = 3;
  localparam int FLG_INVALID   = 4;
  localparam int FLG_W         = 5;

  localparam int FP_MAX_W = 128;

  // Canonical NaN: sign 0, exponent all ones, fraction MSB and LSB set.
  // Callers cast the result down to their own 1+exp_w+man_w width.
  function automatic logic [FP_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < FP_MAX_W; i++) begin
      if ((i >= man_w && i < man_w + exp_w) || i == 0 || i == man_w - 1)
        v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Rounding-increment decision shared by the FP arithmetic blocks.
// Given sign, result LSB and guard/round/sticky, says whether to add one ulp.
module fp_round
  import fp_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  input  logic [1:0] rm,
  output logic       inc
);

  logic any_lost;
  assign any_lost = g | r | s;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE: inc = g && (r || s || lsb);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = !sign && any_lost;
      RM_RDN: inc = sign && any_lost;
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready on both sides,
// per-op rounding mode and tag passthrough. FP_MUL_PIPE_FLAGS_EN adds a flags output.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [1:0]             rm,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [TAG_W-1:0]       out_tag
`ifdef FP_MUL_PIPE_FLAGS_EN
  ,
  output logic [FLG_W-1:0]       flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int PW = 2 * M;
  localparam int XW = EXP_W + 2;

  localparam logic [W-1:0]  CNAN   = W'(canon_nan(EXP_W, MAN_W));
  localparam logic [XW-1:0] BIAS_X = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [XW-1:0] EMAX_X = {2'b00, {EXP_W{1'b1}}};

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)
      return CLS_ZERO;  // subnormals are treated as zero
    else if (&e)
      return (f == '0) ? CLS_INF : CLS_NAN;
    else
      return CLS_NORM;
  endfunction

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------------------------------------------------------- stage 1
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  fp_class_e          cls_a, cls_b, s1_cls_d;
  logic [XW-1:0]      s1_exp_d;
  logic [PW-1:0]      s1_prod_d;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign cls_a = classify(ea, fa);
  assign cls_b = classify(eb, fb);

  // Exponent kept two bits wider so under/overflow are visible as sign/magnitude.
  assign s1_exp_d  = {2'b00, ea} + {2'b00, eb} - BIAS_X;
  assign s1_prod_d = {{M{1'b0}}, 1'b1, fa} * {{M{1'b0}}, 1'b1, fb};

  always_comb begin
    s1_cls_d = CLS_NORM;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN)
      s1_cls_d = CLS_NAN;
    else if ((cls_a == CLS_ZERO && cls_b == CLS_INF) || (cls_a == CLS_INF && cls_b == CLS_ZERO))
      s1_cls_d = CLS_NAN;
    else if (cls_a == CLS_INF || cls_b == CLS_INF)
      s1_cls_d = CLS_INF;
    else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
      s1_cls_d = CLS_ZERO;
  end

  logic               s1_valid;
  logic               s1_sign;
  logic [XW-1:0]      s1_exp;
  logic [PW-1:0]      s1_prod;
  fp_class_e          s1_cls;
  logic [1:0]         s1_rm;
  logic [TAG_W-1:0]   s1_tag;

  // NOTE: datapath registers carry no reset; only the valid bits and the visible outputs need one.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign <= sa ^ sb;
      s1_exp  <= s1_exp_d;
      s1_prod <= s1_prod_d;
      s1_cls  <= s1_cls_d;
      s1_rm   <= rm;
      s1_tag  <= in_tag;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic               msb;
  logic [PW-2:0]      sh;
  logic [XW-1:0]      s2_exp_d;
  logic               unf_d, ovf_d;

  // Product of two [1,2) significands lies in [1,4): at most a one-bit shift.
  assign msb      = s1_prod[PW-1];
  assign sh       = msb ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
  assign s2_exp_d = s1_exp + {{(XW-1){1'b0}}, msb};
  assign unf_d    = s2_exp_d[XW-1] || (s2_exp_d == '0);
  assign ovf_d    = !s2_exp_d[XW-1] && (s2_exp_d >= EMAX_X);

  logic               s2_valid;
  logic               s2_sign;
  logic [XW-1:0]      s2_exp;
  logic [MAN_W-1:0]   s2_frac;
  logic               s2_g, s2_r, s2_s;
  logic               s2_unf, s2_ovf;
  fp_class_e          s2_cls;
  logic [1:0]         s2_rm;
  logic [TAG_W-1:0]   s2_tag;

  always_ff @(posedge clk) begin
    if (!stall) begin
      s2_sign <= s1_sign;
      s2_exp  <= s2_exp_d;
      s2_frac <= sh[PW-2:MAN_W+1];
      s2_g    <= sh[MAN_W];
      s2_r    <= sh[MAN_W-1];
      s2_s    <= |sh[MAN_W-2:0];
      s2_unf  <= unf_d;
      s2_ovf  <= ovf_d;
      s2_cls  <= s1_cls;
      s2_rm   <= s1_rm;
      s2_tag  <= s1_tag;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic               round_inc, carry, ovf, to_inf;
  logic [MAN_W-1:0]   frac_r;
  logic [XW-1:0]      exp_r;
  logic [W-1:0]       res_d;

  fp_round u_round (
    .sign (s2_sign),
    .lsb  (s2_frac[0]),
    .g    (s2_g),
    .r    (s2_r),
    .s    (s2_s),
    .rm   (s2_rm),
    .inc  (round_inc)
  );

  // A carry out of the fraction leaves it all zeros and bumps the exponent.
  assign {carry, frac_r} = {1'b0, s2_frac} + {{MAN_W{1'b0}}, round_inc};
  assign exp_r  = s2_exp + {{(XW-1){1'b0}}, carry};
  assign ovf    = s2_ovf || (exp_r == EMAX_X);
  assign to_inf = (s2_rm == RM_RNE) || (s2_rm == RM_RUP && !s2_sign) || (s2_rm == RM_RDN && s2_sign);

  always_comb begin
    res_d = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    case (s2_cls)
      CLS_NAN:  res_d = CNAN;
      CLS_INF:  res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: res_d = {s2_sign, {(W-1){1'b0}}};
      default: begin
        if (s2_unf)
          res_d = {s2_sign, {(W-1){1'b0}}};
        else if (ovf)
          res_d = to_inf ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                         : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all stages advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      res       <= res_d;
      out_tag   <= s2_tag;
    end
  end

`ifdef FP_MUL_PIPE_FLAGS_EN
  logic               s1_nan_in, s1_invalid;
  logic               s2_nan_in, s2_invalid;
  logic [FLG_W-1:0]   flags_d;

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_nan_in  <= (cls_a == CLS_NAN) || (cls_b == CLS_NAN);
      s1_invalid <= (cls_a == CLS_ZERO && cls_b == CLS_INF) || (cls_a == CLS_INF && cls_b == CLS_ZERO);
      s2_nan_in  <= s1_nan_in;
      s2_invalid <= s1_invalid;
    end
  end

  always_comb begin
    flags_d              = '0;
    flags_d[FLG_NAN_IN]  = s2_nan_in;
    flags_d[FLG_INVALID] = s2_invalid;
    if (s2_cls == CLS_NORM) begin
      if (s2_unf) begin
        flags_d[FLG_UNDERFLOW] = 1'b1;
        flags_d[FLG_INEXACT]   = 1'b1;
      end else if (ovf) begin
        flags_d[FLG_OVERFLOW]  = 1'b1;
        flags_d[FLG_INEXACT]   = 1'b1;
      end else begin
        flags_d[FLG_INEXACT]   = s2_g | s2_r | s2_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags <= '0;
    else if (!stall)
      flags <= flags_d;
  end
`endif

endmodule
